if_stage: RTL and testbench

- Instruction-fetch stage plus IF/ID pipeline register, directly upstream of the main control unit.
- Holds the PC, issues one-outstanding fetch requests to instruction memory, and captures returned words into IF/ID.
- Drives op_code and funct to the control unit and decoder.
- Accepts stall from the hazard unit and PC redirects from branch/jump resolution.

---
 rtl/if_stage.sv | 150 +++++++++++++++
 tb/tb_if_stage.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_stage.sv
// rtl/if_stage.sv - instruction fetch stage with one-outstanding fetch FSM, skid buffer and IF/ID register
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        if_id_valid,
    output logic [31:0] if_id_pc,
    output logic [31:0] if_id_pc4,
    output logic [31:0] if_id_instr,
    output logic [5:0]  op_code,
    output logic [5:0]  funct
);

    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_WAIT  = 2'd1,
        S_HOLD  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        kill_q, kill_d;
    logic [31:0] skid_pc_q, skid_pc_d;
    logic [31:0] skid_instr_q, skid_instr_d;
    logic        ifid_valid_q, ifid_valid_d;
    logic [31:0] ifid_pc_q, ifid_pc_d;
    logic [31:0] ifid_pc4_q, ifid_pc4_d;
    logic [31:0] ifid_instr_q, ifid_instr_d;
    logic        req;
    logic        load_ok;
    logic [31:0] redirect_target;

    assign load_ok         = !stall || !ifid_valid_q;
    assign redirect_target = {redirect_pc[31:2], 2'b00};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        kill_d       = kill_q;
        skid_pc_d    = skid_pc_q;
        skid_instr_d = skid_instr_q;
        ifid_valid_d = ifid_valid_q;
        ifid_pc_d    = ifid_pc_q;
        ifid_pc4_d   = ifid_pc4_q;
        ifid_instr_d = ifid_instr_q;
        req          = 1'b0;

        case (state_q)
            S_FETCH: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                end else begin
                    req     = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (redirect_valid) begin
                    pc_d = redirect_target;
                    // With no response yet, the in-flight word is stale and must be dropped on arrival.
                    if (imem_rvalid) begin
                        kill_d  = 1'b0;
                        state_d = S_FETCH;
                    end else begin
                        kill_d = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (kill_q) begin
                        kill_d  = 1'b0;
                        state_d = S_FETCH;
                    end else if (load_ok) begin
                        ifid_valid_d = 1'b1;
                        ifid_pc_d    = pc_q;
                        ifid_pc4_d   = pc_q + 32'd4;
                        ifid_instr_d = imem_rdata;
                        pc_d         = pc_q + 32'd4;
                        state_d      = S_FETCH;
                    end else begin
                        skid_pc_d    = pc_q;
                        skid_instr_d = imem_rdata;
                        state_d      = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (redirect_valid) begin
                    pc_d    = redirect_target;
                    state_d = S_FETCH;
                end else if (load_ok) begin
                    ifid_valid_d = 1'b1;
                    ifid_pc_d    = skid_pc_q;
                    ifid_pc4_d   = skid_pc_q + 32'd4;
                    ifid_instr_d = skid_instr_q;
                    pc_d         = pc_q + 32'd4;
                    state_d      = S_FETCH;
                end
            end
            default: begin
                state_d = S_FETCH;
            end
        endcase

        if (redirect_valid) begin
            ifid_valid_d = 1'b0;
            ifid_instr_d = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_FETCH;
            pc_q         <= RESET_PC;
            kill_q       <= 1'b0;
            skid_pc_q    <= 32'h0;
            skid_instr_q <= 32'h0;
            ifid_valid_q <= 1'b0;
            ifid_pc_q    <= 32'h0;
            ifid_pc4_q   <= 32'h0;
            ifid_instr_q <= 32'h0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            kill_q       <= kill_d;
            skid_pc_q    <= skid_pc_d;
            skid_instr_q <= skid_instr_d;
            ifid_valid_q <= ifid_valid_d;
            ifid_pc_q    <= ifid_pc_d;
            ifid_pc4_q   <= ifid_pc4_d;
            ifid_instr_q <= ifid_instr_d;
        end
    end

    assign imem_req    = req && !rst;
    assign imem_addr   = pc_q;
    assign if_id_valid = ifid_valid_q;
    assign if_id_pc    = ifid_pc_q;
    assign if_id_pc4   = ifid_pc4_q;
    assign if_id_instr = ifid_instr_q;
    assign op_code     = ifid_instr_q[31:26];
    assign funct       = ifid_instr_q[5:0];

endmodule

// File: tb/tb_if_stage.sv
// tb/tb_if_stage.sv - self-checking bench for if_stage
module tb_if_stage;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        redirect_valid = 1'b0;
    logic [31:0] redirect_pc = 32'h0;
    logic        auto_mem = 1'b1;
    logic        man_rvalid = 1'b0;
    logic [31:0] man_rdata = 32'h0;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    logic        imem_req, imem_rvalid, if_id_valid;
    logic [31:0] imem_addr, imem_rdata, if_id_pc, if_id_pc4, if_id_instr;
    logic [5:0]  op_code, funct;

    logic        d2_req, d2_rvalid, d2_valid;
    logic [31:0] d2_addr, d2_rdata, d2_pc, d2_pc4, d2_instr;
    logic [5:0]  d2_op, d2_funct;
    logic        zero_bit = 1'b0;
    logic [31:0] zero_word = 32'h0;

    always #5 clk = ~clk;

    assign imem_rvalid = auto_mem ? mem_rvalid : man_rvalid;
    assign imem_rdata  = auto_mem ? mem_rdata  : man_rdata;

    always_ff @(posedge clk) begin
        mem_rvalid <= auto_mem && imem_req && !rst;
        mem_rdata  <= imem_addr | 32'h2000_0000;
        d2_rvalid  <= d2_req && !rst;
        d2_rdata   <= d2_addr | 32'h2000_0000;
    end

    if_stage dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .stall(stall),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .if_id_valid(if_id_valid), .if_id_pc(if_id_pc), .if_id_pc4(if_id_pc4),
        .if_id_instr(if_id_instr), .op_code(op_code), .funct(funct)
    );

    if_stage #(.RESET_PC(32'hFFFF_FFFC)) dut2 (
        .clk(clk), .rst(rst), .imem_req(d2_req), .imem_addr(d2_addr),
        .imem_rvalid(d2_rvalid), .imem_rdata(d2_rdata), .stall(zero_bit),
        .redirect_valid(zero_bit), .redirect_pc(zero_word),
        .if_id_valid(d2_valid), .if_id_pc(d2_pc), .if_id_pc4(d2_pc4),
        .if_id_instr(d2_instr), .op_code(d2_op), .funct(d2_funct)
    );

    typedef struct {
        logic        stall;
        logic        exp_req;
        logic [31:0] exp_addr;
    } vec_t;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] instr;
    } exp_t;

    vec_t fr[12];
    exp_t sb[$];
    int   n_vec = 0;
    int   n_err = 0;
    logic prev_rv;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic push(input logic [31:0] pc, input logic [31:0] instr);
        exp_t e;
        e.pc    = pc;
        e.pc4   = pc + 32'd4;
        e.instr = instr;
        sb.push_back(e);
    endtask

    task automatic pop_check(input string nm);
        exp_t e;
        if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL %s: scoreboard empty when output expected", nm);
        end else begin
            e = sb.pop_front();
            chk({nm, "_valid"}, {31'h0, if_id_valid}, 32'h1);
            chk({nm, "_pc"}, if_id_pc, e.pc);
            chk({nm, "_pc4"}, if_id_pc4, e.pc4);
            chk({nm, "_instr"}, if_id_instr, e.instr);
            chk({nm, "_op"}, {26'h0, op_code}, {26'h0, e.instr[31:26]});
            chk({nm, "_funct"}, {26'h0, funct}, {26'h0, e.instr[5:0]});
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_req(input string nm, input logic exp_req, input logic [31:0] exp_addr);
        chk({nm, "_req"}, {31'h0, imem_req}, {31'h0, exp_req});
        if (exp_req) chk({nm, "_addr"}, imem_addr, exp_addr);
    endtask

    task automatic chk_flushed(input string nm);
        chk({nm, "_valid"}, {31'h0, if_id_valid}, 32'h0);
        chk({nm, "_instr"}, if_id_instr, 32'h0);
    endtask

    initial begin
        for (int k = 0; k < 12; k++) begin
            fr[k].stall    = 1'b0;
            fr[k].exp_req  = (k % 2 == 0);
            fr[k].exp_addr = 32'(4 * (k / 2));
        end

        tick();
        tick();
        @(negedge clk);
        chk("rst_req", {31'h0, imem_req}, 32'h0);
        chk_flushed("rst");
        chk("rst_pc", if_id_pc, 32'h0);
        chk("rst_pc4", if_id_pc4, 32'h0);
        tick();
        rst = 1'b0;

        prev_rv = 1'b0;
        for (int k = 0; k < 12; k++) begin
            stall = fr[k].stall;
            @(negedge clk);
            chk("fr_req", {31'h0, imem_req}, {31'h0, fr[k].exp_req});
            chk("fr_addr", imem_addr, fr[k].exp_addr);
            if (prev_rv) begin
                pop_check("fr");
                chk("fr_opcode", {26'h0, op_code}, 32'h8);
            end
            if (imem_req) push(imem_addr, imem_addr | 32'h2000_0000);
            prev_rv = imem_rvalid;
            if (k == 0) chk("wrap_first_addr", d2_addr, 32'hFFFF_FFFC);
            if (k == 2) begin
                chk("wrap_second_addr", d2_addr, 32'h0);
                chk("wrap_pc", d2_pc, 32'hFFFF_FFFC);
                chk("wrap_pc4", d2_pc4, 32'h0);
            end
            tick();
        end
        auto_mem = 1'b0;

        // stall held for four cycles while a response returns
        stall = 1'b1;
        @(negedge clk);
        pop_check("s0");
        chk_req("s0", 1'b1, 32'd24);
        tick();
        man_rvalid = 1'b1;
        man_rdata  = 32'h8C22_0004;
        push(32'd24, 32'h8C22_0004);
        @(negedge clk);
        chk("s1_hold_pc", if_id_pc, 32'd20);
        chk_req("s1", 1'b0, 32'd0);
        tick();
        man_rvalid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            chk_req("s_hold", 1'b0, 32'd0);
            chk("s_hold_pc", if_id_pc, 32'd20);
            chk("s_hold_instr", if_id_instr, 32'h2000_0014);
            tick();
        end
        stall = 1'b0;
        @(negedge clk);
        chk_req("s4", 1'b0, 32'd0);
        chk("s4_pc", if_id_pc, 32'd20);
        tick();
        @(negedge clk);
        pop_check("s5");
        chk("s5_opcode", {26'h0, op_code}, 32'h23);
        chk_req("s5", 1'b1, 32'd28);
        tick();

        // redirect while waiting, stale response three cycles later
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        @(negedge clk);
        chk_req("r0", 1'b0, 32'd0);
        tick();
        redirect_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            man_rvalid = (i == 2);
            man_rdata  = 32'hDEAD_BEEF;
            @(negedge clk);
            chk_flushed("r_wait");
            chk_req("r_wait", 1'b0, 32'd0);
            chk("r_wait_addr", imem_addr, 32'h100);
            tick();
        end
        man_rvalid = 1'b0;
        @(negedge clk);
        chk_flushed("r4");
        chk_req("r4", 1'b1, 32'h100);
        tick();
        man_rvalid = 1'b1;
        man_rdata  = 32'h0000_0020;
        push(32'h100, 32'h0000_0020);
        tick();
        man_rvalid = 1'b0;
        @(negedge clk);
        pop_check("r6");
        chk_req("r6", 1'b1, 32'h104);
        tick();

        // redirect coincident with a response
        man_rvalid     = 1'b1;
        man_rdata      = 32'hFFFF_FFFF;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0200;
        tick();
        man_rvalid     = 1'b0;
        redirect_valid = 1'b0;
        @(negedge clk);
        chk_flushed("q1");
        chk_req("q1", 1'b1, 32'h200);
        tick();
        man_rvalid = 1'b1;
        man_rdata  = 32'h1111_1111;
        push(32'h200, 32'h1111_1111);
        tick();
        man_rvalid = 1'b0;
        stall      = 1'b1;
        @(negedge clk);
        pop_check("q3");
        chk_req("q3", 1'b1, 32'h204);
        tick();

        // redirect while the skid buffer holds a word under stall
        man_rvalid = 1'b1;
        man_rdata  = 32'h2222_2222;
        tick();
        man_rvalid     = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0300;
        @(negedge clk);
        chk_req("q5", 1'b0, 32'd0);
        chk("q5_instr", if_id_instr, 32'h1111_1111);
        tick();
        redirect_valid = 1'b0;
        @(negedge clk);
        chk_flushed("q6");
        chk_req("q6", 1'b1, 32'h300);
        tick();
        stall = 1'b0;
        @(negedge clk);
        chk_flushed("q7");
        chk_req("q7", 1'b0, 32'd0);
        tick();

        // reset mid-WAIT with a response in the same cycle
        rst        = 1'b1;
        man_rvalid = 1'b1;
        man_rdata  = 32'h3333_3333;
        @(negedge clk);
        chk_req("q8", 1'b0, 32'd0);
        tick();
        rst        = 1'b0;
        man_rvalid = 1'b0;
        @(negedge clk);
        chk_flushed("q9");
        chk("q9_pc", if_id_pc, 32'h0);
        chk("q9_pc4", if_id_pc4, 32'h0);
        chk("q9_op", {26'h0, op_code}, 32'h0);
        chk_req("q9", 1'b1, 32'h0);
        tick();
        man_rvalid = 1'b1;
        man_rdata  = 32'h8C22_0004;
        push(32'h0, 32'h8C22_0004);
        tick();
        man_rvalid = 1'b0;
        @(negedge clk);
        pop_check("q11");
        chk("sb_drained", sb.size(), 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
